// File: rtl/lab3_pkg.sv
// Shared definitions for the round-robin arbiter/encoder: requester count,
// index width and the controller state encoding.
package lab3_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating first-set picker: finds the first set request at or
// above ptr, wrapping from the top index back to 0.
module rr_pick
  import lab3_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output gets a default before the search loop, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // The index adder wraps modulo N_REQ because N_REQ == 2**IDX_W.
      cand = ptr + IDX_W'(i);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_enc_ctrl.sv
// Round-robin arbiter with registered one-hot grant, binary index and a
// hold-limit timeout. A grant is always followed by one idle cycle.
module rr_arb_enc_ctrl
  import lab3_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_e            state, state_n;
  logic [IDX_W-1:0]  ptr, ptr_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [N_REQ-1:0]  grant_n;
  logic [IDX_W-1:0]  grant_idx_n;
  logic              grant_valid_n;
  logic              timeout_n;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              at_limit;
  logic              still_wanted;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign at_limit     = (hold_cnt == HOLD_MAX);
  assign still_wanted = req[grant_idx] && enable;

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    hold_n        = hold_cnt;
    grant_n       = grant;
    grant_idx_n   = grant_idx;
    grant_valid_n = grant_valid;
    timeout_n     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        grant_n       = '0;
        grant_idx_n   = '0;
        grant_valid_n = 1'b0;
        hold_n        = '0;
        if (enable && pick_any) begin
          state_n       = ST_GRANT;
          grant_n       = pick_onehot;
          grant_idx_n   = pick_idx;
          grant_valid_n = 1'b1;
          hold_n        = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (!still_wanted || at_limit) begin
          state_n       = ST_IDLE;
          grant_n       = '0;
          grant_idx_n   = '0;
          grant_valid_n = 1'b0;
          hold_n        = '0;
          ptr_n         = grant_idx + IDX_W'(1);
          // A requester release or enable drop wins over the hold limit.
          timeout_n     = still_wanted && at_limit;
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_n;
      grant       <= grant_n;
      grant_idx   <= grant_idx_n;
      grant_valid <= grant_valid_n;
      timeout     <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_arb_enc_ctrl.sv
// Directed bench for rr_arb_enc_ctrl: each scenario task drives vectors and
// compares {grant, grant_idx, grant_valid, timeout} against hand-derived values.
module tb_rr_arb_enc_ctrl;

  logic        clock;
  logic        reset;
  logic [15:0] req;
  logic        enable;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  logic [21:0] obs;
  logic [21:0] want;
  assign obs = {grant, grant_idx, grant_valid, timeout};

  rr_arb_enc_ctrl #(.MAX_HOLD(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .enable      (enable),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [21:0] exp_out(input int idx, input logic v, input logic to);
    logic [15:0] g;
    g = v ? (16'h0001 << idx) : 16'h0000;
    return {g, (v ? 4'(idx) : 4'd0), v, to};
  endfunction

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 16'h0; enable = 1'b0;
    step(); step();
    want = exp_out(0, 1'b0, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL reset_state got=%h want=%h", obs, want);
    end
    reset = 1'b0;
    step();
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL idle_after_reset got=%h want=%h", obs, want);
    end
  endtask

  // Pointer 0 -> index 0 granted; release leaves pointer at 1.
  task automatic test_single();
    req = 16'h0001; enable = 1'b1;
    step();
    want = exp_out(0, 1'b1, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL single_grant got=%h want=%h", obs, want);
    end
    req = 16'h0000;
    step();
    want = exp_out(0, 1'b0, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL single_release got=%h want=%h", obs, want);
    end
  endtask

  // Pointer 1: grants go 15, 0, 15, 0 with an idle cycle between each.
  task automatic test_alternate();
    int exp_idx;
    for (int r = 0; r < 4; r++) begin
      exp_idx = (r % 2 == 0) ? 15 : 0;
      req = 16'h8001;
      for (int c = 0; c < 2; c++) begin
        step();
        want = exp_out(exp_idx, 1'b1, 1'b0);
        checks++;
        if (obs !== want) begin
          failures++; $display("FAIL alt_grant r=%0d c=%0d got=%h want=%h", r, c, obs, want);
        end
      end
      req = 16'h8001 & ~(16'h0001 << exp_idx);
      step();
      want = exp_out(0, 1'b0, 1'b0);
      checks++;
      if (obs !== want) begin
        failures++; $display("FAIL alt_idle r=%0d got=%h want=%h", r, obs, want);
      end
    end
    req = 16'h0000;
  endtask

  // Grant 15, release, then all requesting: pointer must wrap to 0.
  task automatic test_wrap();
    req = 16'h8000;
    step();
    want = exp_out(15, 1'b1, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL wrap_grant15 got=%h want=%h", obs, want);
    end
    req = 16'h0000;
    step();
    req = 16'hFFFF;
    step();
    want = exp_out(0, 1'b1, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL wrap_to_0 got=%h want=%h", obs, want);
    end
    req = 16'h0000;
    step();
  endtask

  // Pointer 1, requester 4 held: 8 grant cycles, timeout idle cycle, regrant.
  task automatic test_timeout();
    req = 16'h0010;
    for (int c = 1; c <= 8; c++) begin
      step();
      want = exp_out(4, 1'b1, 1'b0);
      checks++;
      if (obs !== want) begin
        failures++; $display("FAIL hold_cycle c=%0d got=%h want=%h", c, obs, want);
      end
    end
    step();
    want = exp_out(0, 1'b0, 1'b1);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL timeout_pulse got=%h want=%h", obs, want);
    end
    step();
    want = exp_out(4, 1'b1, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL regrant_after_timeout got=%h want=%h", obs, want);
    end
    req = 16'h0000;
    step();
    want = exp_out(0, 1'b0, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL release_after_regrant got=%h want=%h", obs, want);
    end
  endtask

  // Release coincides with hold count reaching the limit: no timeout.
  task automatic test_release_at_limit();
    req = 16'h0010;
    for (int c = 1; c <= 8; c++) step();
    want = exp_out(4, 1'b1, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL limit_reached got=%h want=%h", obs, want);
    end
    req = 16'h0000;
    step();
    want = exp_out(0, 1'b0, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL release_at_limit got=%h want=%h", obs, want);
    end
  endtask

  // Pointer 5: grant 5, other requests ignored, enable drop revokes cleanly.
  task automatic test_enable_drop();
    req = 16'h0020;
    step();
    req = 16'hFFFF;
    step();
    want = exp_out(5, 1'b1, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL others_ignored got=%h want=%h", obs, want);
    end
    enable = 1'b0;
    step();
    want = exp_out(0, 1'b0, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL enable_drop got=%h want=%h", obs, want);
    end
    step();
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL disabled_idle got=%h want=%h", obs, want);
    end
    enable = 1'b1;
    req = 16'h0000;
  endtask

  // Pointer 6: grant 2, async reset mid-grant, then restart from pointer 0.
  task automatic test_reset_mid_grant();
    req = 16'h0004;
    step();
    want = exp_out(2, 1'b1, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL pre_reset_grant got=%h want=%h", obs, want);
    end
    #2 reset = 1'b1;
    #1;
    want = exp_out(0, 1'b0, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL async_reset_drop got=%h want=%h", obs, want);
    end
    step();
    reset = 1'b0;
    req = 16'h0081;
    step();
    want = exp_out(0, 1'b1, 1'b0);
    checks++;
    if (obs !== want) begin
      failures++; $display("FAIL restart_ptr0 got=%h want=%h", obs, want);
    end
    req = 16'h0000;
    step();
  endtask

  initial begin
    reset = 1'b1; req = 16'h0; enable = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_wrap();
    test_timeout();
    test_release_at_limit();
    test_enable_drop();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
